// File: rtl/id_ex_ctrl_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_ctrl_stage_pkg
// Brief    : Opcodes, ALU op classes and the main-control bundle type.
// Revision : 1.0
// ============================================================================
package id_ex_ctrl_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_ctrl_stage_main_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : main_ctrl_decode
// Brief    : Combinational opcode -> main control bundle and illegal flag.
// Revision : 1.0
// ============================================================================
module main_ctrl_decode
  import id_ex_ctrl_stage_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_ctrl_stage
// Brief    : ID decode, load-use/flush/hold control and the ID/EX register.
// Revision : 1.0
// ============================================================================
module id_ex_ctrl_stage
  import id_ex_ctrl_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             flush,
  input  logic             ext_hold,
  output logic             id_stall,
  output logic             ex_valid,
  output logic [1:0]       ex_alu_op,
  output logic [5:0]       ex_func,
  output logic             ex_reg_dst,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_reg_write,
  output logic             ex_branch,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [31:0]      ex_imm,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [5:0]       w_opcode;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  ctrl_t            w_ctrl;
  logic             w_illegal;
  logic             w_load_use;
  logic             w_take;
  logic             w_count;

  logic             r_valid;
  ctrl_t            r_ctrl;
  logic [5:0]       r_func;
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_rd;
  logic [31:0]      r_imm;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = id_instr[31:26];
  assign w_rs     = id_instr[25:21];
  assign w_rt     = id_instr[20:16];

  main_ctrl_decode u_decode (
    .opcode  (w_opcode),
    .ctrl    (w_ctrl),
    .illegal (w_illegal)
  );

  assign w_load_use = r_valid && r_ctrl.mem_read && (r_rt != 5'd0) && id_valid &&
                      ((r_rt == w_rs) || ((r_rt == w_rt) && uses_rt(w_opcode)));

  // Flush outranks load-use, so a squashed dependent never stalls the front end.
  assign id_stall = ext_hold || (!flush && w_load_use);
  assign w_take   = !flush && !w_load_use && id_valid && !w_illegal;
  assign w_count  = flush || w_load_use || (id_valid && w_illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_func    <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else if (!ext_hold) begin
      r_illegal <= !flush && !w_load_use && id_valid && w_illegal;
      if (w_take) begin
        r_valid <= 1'b1;
        r_ctrl  <= w_ctrl;
        r_func  <= (w_ctrl.alu_op == ALUOP_FUNC) ? id_instr[5:0] : 6'd0;
        r_rs    <= w_rs;
        r_rt    <= w_rt;
        r_rd    <= id_instr[15:11];
        r_imm   <= {{16{id_instr[15]}}, id_instr[15:0]};
      end else begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_func  <= '0;
        r_rs    <= '0;
        r_rt    <= '0;
        r_rd    <= '0;
        r_imm   <= '0;
      end
      if (w_count && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_func       = r_func;
  assign ex_reg_dst    = r_ctrl.reg_dst;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_branch     = r_ctrl.branch;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_imm        = r_imm;
  assign ex_illegal    = r_illegal;
  assign bubble_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_ctrl_stage
// Brief    : Directed self-checking bench for id_ex_ctrl_stage.
// Revision : 1.0
// ============================================================================
module tb_id_ex_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        flush;
  logic        ext_hold;

  logic        id_stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_read;
  logic        ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_illegal;
  logic [1:0]  ex_alu_op;
  logic [5:0]  ex_func;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_imm;
  logic [15:0] bubble_cnt;

  logic        d2_id_stall, d2_ex_valid, d2_ex_reg_dst, d2_ex_alu_src, d2_ex_mem_read;
  logic        d2_ex_mem_write, d2_ex_mem_to_reg, d2_ex_reg_write, d2_ex_branch, d2_ex_illegal;
  logic [1:0]  d2_ex_alu_op;
  logic [5:0]  d2_ex_func;
  logic [4:0]  d2_ex_rs, d2_ex_rt, d2_ex_rd;
  logic [31:0] d2_ex_imm;
  logic [1:0]  d2_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .flush(flush), .ext_hold(ext_hold), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_alu_op(ex_alu_op), .ex_func(ex_func), .ex_reg_dst(ex_reg_dst),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm),
    .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt)
  );

  id_ex_ctrl_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .flush(flush), .ext_hold(ext_hold), .id_stall(d2_id_stall), .ex_valid(d2_ex_valid),
    .ex_alu_op(d2_ex_alu_op), .ex_func(d2_ex_func), .ex_reg_dst(d2_ex_reg_dst),
    .ex_alu_src(d2_ex_alu_src), .ex_mem_read(d2_ex_mem_read), .ex_mem_write(d2_ex_mem_write),
    .ex_mem_to_reg(d2_ex_mem_to_reg), .ex_reg_write(d2_ex_reg_write), .ex_branch(d2_ex_branch),
    .ex_rs(d2_ex_rs), .ex_rt(d2_ex_rt), .ex_rd(d2_ex_rd), .ex_imm(d2_ex_imm),
    .ex_illegal(d2_ex_illegal), .bubble_cnt(d2_bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    id_instr = 32'h0;
    id_valid = 1'b0;
    flush    = 1'b0;
    ext_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ex_valid, ex_alu_op, ex_func, ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write,
         ex_mem_to_reg, ex_reg_write, ex_branch, ex_rs, ex_rt, ex_rd, ex_imm, ex_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b op=%b func=%h imm=%h, expected all zero",
               ex_valid, ex_alu_op, ex_func, ex_imm);
    end
    checks++;
    if (bubble_cnt !== 16'd0 || id_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: got cnt=%0d stall=%b, expected 0/0", bubble_cnt, id_stall);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    id_instr = 32'h00221820; id_valid = 1'b1;
    step();
    checks++;
    if (ex_alu_op !== 2'b10 || ex_func !== 6'b100000 || ex_reg_dst !== 1'b1 ||
        ex_reg_write !== 1'b1 || ex_rd !== 5'd3 || ex_valid !== 1'b1 ||
        ex_rs !== 5'd1 || ex_rt !== 5'd2 || ex_alu_src !== 1'b0 || ex_mem_read !== 1'b0) begin
      errors++;
      $display("FAIL rtype_add: got op=%b func=%b rd=%0d valid=%b dst=%b wr=%b, expected 10/100000/3/1/1/1",
               ex_alu_op, ex_func, ex_rd, ex_valid, ex_reg_dst, ex_reg_write);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    id_instr = 32'h8C220004; id_valid = 1'b1;
    step();
    checks++;
    if (ex_mem_read !== 1'b1 || ex_mem_to_reg !== 1'b1 || ex_alu_src !== 1'b1 ||
        ex_alu_op !== 2'b00 || ex_func !== 6'd0 || ex_rt !== 5'd2 || ex_imm !== 32'd4) begin
      errors++;
      $display("FAIL lw_decode: got mr=%b m2r=%b src=%b op=%b func=%h rt=%0d imm=%h",
               ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_alu_op, ex_func, ex_rt, ex_imm);
    end
    id_instr = 32'h00452022;
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got id_stall=%b, expected 1", id_stall);
    end
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rt !== 5'd0 || bubble_cnt !== 16'd1 ||
        id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble: got valid=%b mr=%b cnt=%0d stall=%b, expected 0/0/1/0",
               ex_valid, ex_mem_read, bubble_cnt, id_stall);
    end
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_alu_op !== 2'b10 || ex_func !== 6'b100010 || ex_rd !== 5'd4 ||
        bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_resume: got valid=%b op=%b func=%b rd=%0d cnt=%0d, expected 1/10/100010/4/1",
               ex_valid, ex_alu_op, ex_func, ex_rd, bubble_cnt);
    end
    // rt is addi's destination, not a source: no hazard
    id_instr = 32'h8C220004;
    step();
    id_instr = 32'h20620001;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_addi_rt: got id_stall=%b, expected 0", id_stall);
    end
    // load into $0 never creates a hazard
    id_instr = 32'h8C200004;
    step();
    id_instr = 32'h00001820;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_zero_reg: got id_stall=%b, expected 0", id_stall);
    end
    // id_valid=0 bubble leaves the counter alone
    id_valid = 1'b0;
    step();
    checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL idle_bubble: got valid=%b cnt=%0d, expected 0/1", ex_valid, bubble_cnt);
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    id_instr = 32'h1022FFFF; id_valid = 1'b1;
    step();
    checks++;
    if (ex_alu_op !== 2'b01 || ex_branch !== 1'b1 || ex_imm !== 32'hFFFFFFFF ||
        ex_reg_write !== 1'b0 || ex_func !== 6'd0 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL beq_decode: got op=%b br=%b imm=%h wr=%b func=%h, expected 01/1/ffffffff/0/00",
               ex_alu_op, ex_branch, ex_imm, ex_reg_write, ex_func);
    end
    id_instr = 32'h00221820; flush = 1'b1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got id_stall=%b, expected 0", id_stall);
    end
    step();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_branch !== 1'b0 || ex_imm !== 32'd0 || ex_alu_op !== 2'b00 ||
        bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_bubble: got valid=%b br=%b imm=%h cnt=%0d, expected 0/0/0/1",
               ex_valid, ex_branch, ex_imm, bubble_cnt);
    end
  endtask

  task automatic test_hold();
    do_reset();
    id_instr = 32'h20230005; id_valid = 1'b1;
    step();
    id_instr = 32'h00221820; ext_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      #1;
      checks++;
      if (id_stall !== 1'b1) begin
        errors++;
        $display("FAIL hold_stall[%0d]: got id_stall=%b, expected 1", i, id_stall);
      end
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_alu_src !== 1'b1 || ex_reg_write !== 1'b1 || ex_alu_op !== 2'b00 ||
          ex_rt !== 5'd3 || ex_rs !== 5'd1 || ex_imm !== 32'd5 || bubble_cnt !== 16'd0) begin
        errors++;
        $display("FAIL hold_keep[%0d]: got valid=%b src=%b rt=%0d imm=%h cnt=%0d, expected 1/1/3/5/0",
                 i, ex_valid, ex_alu_src, ex_rt, ex_imm, bubble_cnt);
      end
    end
    ext_hold = 1'b0; flush = 1'b0;
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_alu_op !== 2'b10 || ex_rd !== 5'd3) begin
      errors++;
      $display("FAIL hold_release: got valid=%b op=%b rd=%0d, expected 1/10/3", ex_valid, ex_alu_op, ex_rd);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    id_instr = 32'hFC000000; id_valid = 1'b1;
    step();
    checks++;
    if (ex_valid !== 1'b0 || ex_illegal !== 1'b1 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL illegal_flag: got valid=%b ill=%b cnt=%0d, expected 0/1/1", ex_valid, ex_illegal, bubble_cnt);
    end
    ext_hold = 1'b1;
    step();
    checks++;
    if (ex_illegal !== 1'b1 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL illegal_hold: got ill=%b cnt=%0d, expected 1/1", ex_illegal, bubble_cnt);
    end
    ext_hold = 1'b0; id_instr = 32'h00221820;
    step();
    checks++;
    if (ex_illegal !== 1'b0 || ex_valid !== 1'b1 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL illegal_clear: got ill=%b valid=%b cnt=%0d, expected 0/1/1", ex_illegal, ex_valid, bubble_cnt);
    end
  endtask

  task automatic test_saturate_and_async_reset();
    do_reset();
    id_instr = 32'h00221820; id_valid = 1'b1; flush = 1'b1;
    for (int i = 0; i < 5; i++) step();
    flush = 1'b0;
    checks++;
    if (d2_bubble_cnt !== 2'd3 || bubble_cnt !== 16'd5) begin
      errors++;
      $display("FAIL saturate: got narrow=%0d wide=%0d, expected 3/5", d2_bubble_cnt, bubble_cnt);
    end
    step();
    ext_hold = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_op !== 2'b00 || ex_func !== 6'd0 ||
        ex_rd !== 5'd0 || bubble_cnt !== 16'd0 || d2_bubble_cnt !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b op=%b func=%h rd=%0d cnt=%0d, expected all 0",
               ex_valid, ex_alu_op, ex_func, ex_rd, bubble_cnt);
    end
    ext_hold = 1'b0;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got id_stall=%b, expected 0", id_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_branch_flush();
    test_hold();
    test_illegal();
    test_saturate_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
- Decode-side producer of the ALU-control interface: decodes the IF/ID instruction into main control signals, including the 2-bit ALU op class and the 6-bit function field.
- Registers these, with operand fields, into the ID/EX pipeline register that feeds the EX-stage ALU control decoder.
- Owns load-use hazard detection, bubble insertion, branch flush and downstream hold for the 5-stage pipeline.

Parameters:
- CNT_W, 16, width of the saturating inserted-bubble counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_instr  in  32  instruction from IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- flush  in  1  branch taken in EX; squash ID.
- ext_hold  in  1  downstream stall; freeze ID/EX.
- id_stall  out  1  combinational; freeze PC and IF/ID.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_alu_op  out  2  00 add (lw/sw/addi), 01 sub (beq), 10 R-type (use func).
- ex_func  out  6  id_instr[5:0]; zeroed for non-R-type.
- ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch  out  1 each  main control.
- ex_rs, ex_rt, ex_rd  out  5 each  register fields.
- ex_imm  out  32  sign-extended id_instr[15:0].
- ex_illegal  out  1  one-cycle flag: an unsupported opcode was squashed.
- bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating.

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs 0, ex_valid=0, bubble_cnt=0. Release is synchronous to clk.
- Decode, on opcode id_instr[31:26]:
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10, func passed through.
  - 100011 lw: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00.
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00.
  - 000100 beq: branch=1, alu_op=01.
  - 001000 addi: alu_src=1, reg_write=1, alu_op=00.
  - Any other opcode is illegal.
- Load-use condition: ex_valid & ex_mem_read & ex_rt!=0 & id_valid & (ex_rt==id_instr[25:21] | (ex_rt==id_instr[20:16] & opcode in {R-type, sw, beq})).
- Per-edge priority, highest first:
  1. ext_hold=1: ID/EX holds all contents; id_stall=1; counter unchanged. flush is ignored while ext_hold=1.
  2. flush=1: load bubble; id_stall=0; counter +1.
  3. Load-use: load bubble; id_stall=1; counter +1.
  4. id_valid=1 with illegal opcode: load bubble; ex_illegal=1 for one cycle; counter +1.
  5. id_valid=0: load bubble; counter unchanged.
  6. Otherwise: load decoded instruction; ex_valid=1.
- Bubble: every control output 0, ex_alu_op=00, ex_func=0, ex_rs/rt/rd=0, ex_imm=0, ex_valid=0.
- ex_illegal is 0 in every cycle except the one following an illegal squash. It is held, not re-pulsed, when ext_hold=1.
- id_stall is purely combinational from current inputs and ID/EX state. It is never asserted when flush=1 and ext_hold=0.
- Latency: one cycle, ID to EX.
- bubble_cnt saturates at all-ones with no wrap.
- Reset mid-stall: ID/EX is cleared and id_stall drops immediately, since it depends on ex_valid.

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALU op class constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10;
  - a packed control-bundle typedef for the 7 control bits plus alu_op.
- One combinational sub-module, main_ctrl_decode: opcode -> control bundle plus illegal flag.
- This module owns the hazard logic, priority mux, registers and counter.

Test Plan:
- Reset, then id_instr=0x00221820 (add $3,$1,$2), id_valid=1 -> next cycle ex_alu_op=10, ex_func=100000, ex_reg_dst=1, ex_reg_write=1, ex_rd=3, ex_valid=1.
- lw 0x8C220004, then sub 0x00452022 -> during sub in ID, id_stall=1; next edge ID/EX is a bubble, bubble_cnt=1; following edge sub loads with ex_alu_op=10, ex_func=100010.
- beq 0x1022FFFF -> ex_alu_op=01, ex_branch=1, ex_imm=0xFFFFFFFF; flush=1 on the next cycle -> ID/EX bubble, id_stall=0.
- ext_hold=1 for 3 cycles with addi loaded in ID/EX -> ex_* outputs unchanged, id_stall=1, bubble_cnt unchanged; also assert flush during the hold -> ignored.
- id_instr=0xFC000000 (illegal opcode) -> ex_valid=0, ex_illegal=1 for exactly one cycle, bubble_cnt incremented.
- CNT_W=2 with 5 consecutive flushes -> bubble_cnt sticks at 3; rst_n pulsed low mid-hold -> all outputs 0 asynchronously.
